arm_instr_encoder: RTL and testbench

ARM_INSTR_ENCODER -- requirements
Module: arm_instr_encoder

---
 rtl/arm_instr_encoder.sv | 145 ++++++++++++++
 tb/tb_arm_instr_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_instr_encoder.sv
// Instruction-word encoder. It forces each family's fixed bits, re-classifies the result
// to flag bad words, and queues the word and its error flag in a small FIFO with no bypass.
module arm_instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  fam,
    input  logic [3:0]  cond,
    input  logic [27:0] payload,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic [15:0] word_cnt,
    output logic [7:0]  err_cnt
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Overwrite the family-fixed opcode bits of {cond, payload}.
    function automatic logic [31:0] encode_word(input logic [3:0] f, input logic [3:0] c,
                                                input logic [27:0] p);
        logic [31:0] w;
        w = {c, p};
        case (f)
            4'd0:  w[27:25] = 3'b001;
            4'd1:  begin w[27:25] = 3'b000; w[4] = 1'b0; end
            4'd2:  begin w[27:25] = 3'b000; w[7] = 1'b0; w[4] = 1'b1; end
            4'd3:  begin w[27:22] = 6'b000000; w[7:4] = 4'b1001; end
            4'd4:  begin w[27:23] = 5'b00001; w[7:4] = 4'b1001; end
            4'd5:  begin w[27:23] = 5'b00010; w[21:20] = 2'b00; end
            4'd6:  begin w[27:23] = 5'b00110; w[21:20] = 2'b10; end
            4'd7:  begin w[27:23] = 5'b00010; w[21:20] = 2'b10; w[4] = 1'b0; end
            4'd8:  w[27:25] = 3'b010;
            4'd9:  begin w[27:25] = 3'b011; w[4] = 1'b0; end
            4'd10: begin w[27:25] = 3'b000; w[22] = 1'b1; w[7] = 1'b1; w[4] = 1'b1; end
            4'd11: begin w[27:25] = 3'b000; w[22] = 1'b0; w[7] = 1'b1; w[4] = 1'b1; end
            4'd12: begin w[27:23] = 5'b00010; w[21:20] = 2'b00; w[7:4] = 4'b1001; end
            4'd13: w[27:25] = 3'b100;
            4'd14: w[27:25] = 3'b101;
            4'd15: begin w[27:25] = 3'b011; w[4] = 1'b1; end
            default: w = {c, p};
        endcase
        return w;
    endfunction

    // Family decoder: the most specific patterns win, so e.g. swap beats the status-register forms.
    function automatic logic [15:0] classify(input logic [31:0] w);
        logic [15:0] oh;
        oh = 16'h0000;
        if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[7:4] == 4'b1001) oh[12] = 1'b1;
        else if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001)                oh[3]  = 1'b1;
        else if (w[27:23] == 5'b00001 && w[7:4] == 4'b1001)                 oh[4]  = 1'b1;
        else if (w[27:25] == 3'b000 && w[22] == 1'b1 && w[7] == 1'b1 && w[4] == 1'b1) oh[10] = 1'b1;
        else if (w[27:25] == 3'b000 && w[22] == 1'b0 && w[7] == 1'b1 && w[4] == 1'b1) oh[11] = 1'b1;
        else if (w[27:23] == 5'b00010 && w[21:20] == 2'b10 && w[4] == 1'b0) oh[7]  = 1'b1;
        else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00)                 oh[5]  = 1'b1;
        else if (w[27:25] == 3'b000 && w[7] == 1'b0 && w[4] == 1'b1)        oh[2]  = 1'b1;
        else if (w[27:25] == 3'b000 && w[4] == 1'b0)                        oh[1]  = 1'b1;
        else if (w[27:23] == 5'b00110 && w[21:20] == 2'b10)                 oh[6]  = 1'b1;
        else if (w[27:25] == 3'b001)                                        oh[0]  = 1'b1;
        else if (w[27:25] == 3'b011 && w[4] == 1'b1)                        oh[15] = 1'b1;
        else if (w[27:25] == 3'b011)                                        oh[9]  = 1'b1;
        else if (w[27:25] == 3'b010)                                        oh[8]  = 1'b1;
        else if (w[27:25] == 3'b100)                                        oh[13] = 1'b1;
        else if (w[27:25] == 3'b101)                                        oh[14] = 1'b1;
        else                                                                oh = 16'h0000;
        return oh;
    endfunction

    logic [31:0]       mem_r [DEPTH];
    logic [DEPTH-1:0]  err_mem_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     cnt_r;
    logic [15:0]       word_cnt_r;
    logic [7:0]        err_cnt_r;
    logic [31:0]       enc_word_s;
    logic              enc_err_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;

    // Encode and check the incoming request; derive FIFO status and handshakes.
    always_comb begin
        enc_word_s = encode_word(fam, cond, payload);
        enc_err_s  = (cond == 4'hF) || (classify(enc_word_s) != (16'h0001 << fam));
        full_s     = (cnt_r == FULL_CNT);
        empty_s    = (cnt_r == {CW{1'b0}});
        push_s     = in_valid && !full_s;
        pop_s      = !empty_s && out_ready;
    end

    // FIFO storage, pointers, occupancy and delivery/error counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            err_mem_r  <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            word_cnt_r <= 16'h0000;
            err_cnt_r  <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r]     <= enc_word_s;
                err_mem_r[wr_ptr_r] <= enc_err_s;
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                if (enc_err_s && err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'h01;
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end
            if (pop_s) begin
                rd_ptr_r   <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                word_cnt_r <= word_cnt_r + 16'h0001;
            end
            if (push_s && !pop_s) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (pop_s && !push_s) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign out_word  = mem_r[rd_ptr_r];
    assign out_err   = err_mem_r[rd_ptr_r];
    assign word_cnt  = word_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Randomized self-checking bench for arm_instr_encoder: a table-driven reference model
// of the family encodings and decoder priority, with a queue standing in for the FIFO.
module tb_arm_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fam;
    logic [3:0]  cond;
    logic [27:0] payload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;
    logic [15:0] word_cnt;
    logic [7:0]  err_cnt;

    arm_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fam(fam), .cond(cond), .payload(payload), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_err(out_err),
        .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [27:0] fmask [16];
    logic [27:0] fval  [16];
    int          prio  [16] = '{12, 3, 4, 10, 11, 7, 5, 2, 1, 6, 0, 15, 9, 8, 13, 14};
    logic [32:0] mq [$];
    int          m_words;
    int          m_errs;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic add_field(input int f, input int hi, input int lo, input int v);
        for (int b = lo; b <= hi; b++) begin
            fmask[f][b] = 1'b1;
            fval[f][b]  = ((v >> (b - lo)) & 1) != 0;
        end
    endtask

    task automatic build_tables();
        for (int f = 0; f < 16; f++) begin
            fmask[f] = 28'h0;
            fval[f]  = 28'h0;
        end
        add_field(0, 27, 25, 1);
        add_field(1, 27, 25, 0);  add_field(1, 4, 4, 0);
        add_field(2, 27, 25, 0);  add_field(2, 7, 7, 0);  add_field(2, 4, 4, 1);
        add_field(3, 27, 22, 0);  add_field(3, 7, 4, 9);
        add_field(4, 27, 23, 1);  add_field(4, 7, 4, 9);
        add_field(5, 27, 23, 2);  add_field(5, 21, 20, 0);
        add_field(6, 27, 23, 6);  add_field(6, 21, 20, 2);
        add_field(7, 27, 23, 2);  add_field(7, 21, 20, 2); add_field(7, 4, 4, 0);
        add_field(8, 27, 25, 2);
        add_field(9, 27, 25, 3);  add_field(9, 4, 4, 0);
        add_field(10, 27, 25, 0); add_field(10, 22, 22, 1); add_field(10, 7, 7, 1); add_field(10, 4, 4, 1);
        add_field(11, 27, 25, 0); add_field(11, 22, 22, 0); add_field(11, 7, 7, 1); add_field(11, 4, 4, 1);
        add_field(12, 27, 23, 2); add_field(12, 21, 20, 0); add_field(12, 7, 4, 9);
        add_field(13, 27, 25, 4);
        add_field(14, 27, 25, 5);
        add_field(15, 27, 25, 3); add_field(15, 4, 4, 1);
    endtask

    // Reference: {err, word}; a family's forced bits double as its decode pattern.
    function automatic logic [32:0] ref_entry(input logic [3:0] f, input logic [3:0] c,
                                              input logic [27:0] p);
        logic [27:0] body;
        int          got;
        body = (p & ~fmask[f]) | fval[f];
        got  = -1;
        for (int k = 0; k < 16; k++) begin
            if (got < 0 && (body & fmask[prio[k]]) == fval[prio[k]]) got = prio[k];
        end
        return {(c == 4'hF) || (got != int'(f)), c, body};
    endfunction

    task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] c,
                         input logic [27:0] p, input logic rdy);
        in_valid = v; fam = f; cond = c; payload = p; out_ready = rdy;
    endtask

    task automatic drive_rand(input logic v, input logic rdy);
        logic [3:0] c;
        c = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(14));
        drive(v, 4'($urandom_range(15)), c, 28'($urandom), rdy);
    endtask

    // One clock: check outputs against the model before the edge, advance both, check counters.
    task automatic step();
        bit m_push;
        bit m_pop;
        m_push = in_valid && (mq.size() < DEPTH);
        m_pop  = out_ready && (mq.size() > 0);
        chk_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk_eq("out_word", out_word, mq[0][31:0]);
            chk_eq("out_err", 32'(out_err), 32'(mq[0][32]));
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_words = 0;
            m_errs  = 0;
        end else begin
            if (m_pop) begin
                void'(mq.pop_front());
                m_words++;
            end
            if (m_push) begin
                mq.push_back(ref_entry(fam, cond, payload));
                if (mq[mq.size()-1][32]) m_errs++;
            end
        end
        #1;
        chk_eq("word_cnt", 32'(word_cnt), 32'(m_words[15:0]));
        chk_eq("err_cnt", 32'(err_cnt), (m_errs > 255) ? 32'd255 : 32'(m_errs));
    endtask

    initial begin
        build_tables();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_words = 0;
        m_errs  = 0;
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
        chk_eq("rst_out_word", out_word, 32'h0000_0000);
        chk_eq("rst_out_err", 32'(out_err), 32'd0);
        chk_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;

        // Branch with zero payload: visible one cycle later, counted after pop.
        drive(1'b1, 4'd14, 4'hE, 28'h0, 1'b0);
        step();
        chk_eq("b_word", out_word, 32'hEA00_0000);
        chk_eq("b_err", 32'(out_err), 32'd0);
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b1);
        step();
        chk_eq("b_word_cnt", 32'(word_cnt), 32'd1);

        // Multiply with all-ones payload.
        drive(1'b1, 4'd3, 4'hE, 28'hFFF_FFFF, 1'b0);
        step();
        chk_eq("mul_word", out_word, 32'hE03F_FF9F);
        chk_eq("mul_err", 32'(out_err), 32'd0);
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b1);
        step();

        // Register data-processing that re-decodes as a status-register form.
        drive(1'b1, 4'd1, 4'hE, 28'h100_0000, 1'b0);
        step();
        chk_eq("recls_err", 32'(out_err), 32'd1);
        chk_eq("recls_err_cnt", 32'(err_cnt), 32'd1);
        drive(1'b1, 4'd13, 4'hF, 28'h0, 1'b1);
        step();
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b0);
        chk_eq("nv_err", 32'(out_err), 32'd1);
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b1);
        step();

        // Fill with the consumer stalled, then stream through at full rate and drain.
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(1'b1, 1'b0);
            step();
        end
        chk_eq("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive_rand(1'b1, 1'b1);
            step();
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_rand(1'b0, 1'b1);
            step();
        end

        // Reset with two words queued and handshakes offered in the same cycle.
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1, 1'b0);
            step();
        end
        rst_n = 1'b0;
        drive_rand(1'b1, 1'b1);
        step();
        rst_n = 1'b1;
        chk_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        chk_eq("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk_eq("mid_rst_err_cnt", 32'(err_cnt), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(199) != 0);
            drive_rand($urandom_range(3) != 0, $urandom_range(2) != 0);
            step();
        end
        rst_n = 1'b1;

        // Long stream: 65537 deliveries wrap word_cnt to 1; 300 bad words saturate err_cnt.
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 4'($urandom_range(15)), (i < 300) ? 4'hF : 4'hE, 28'($urandom), 1'b1);
            step();
        end
        drive(1'b0, 4'd0, 4'h0, 28'h0, 1'b1);
        step();
        chk_eq("wrap_word_cnt", 32'(word_cnt), 32'd1);
        chk_eq("sat_err_cnt", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
